// File: rtl/seq_pkg.sv
// Shared constants and types for the instruction sequencer: peripheral ids,
// unit register offsets, opcodes, FSM states and the instruction layout.
package seq_pkg;

  localparam logic [3:0] MEM_ID    = 4'd1;
  localparam logic [3:0] ROM_ID    = 4'd2;
  localparam logic [3:0] MATRIX_ID = 4'd3;
  localparam logic [3:0] INT_ID    = 4'd4;

  localparam logic [11:0] OFF_A   = 12'h000;
  localparam logic [11:0] OFF_B   = 12'h001;
  localparam logic [11:0] OFF_OP  = 12'h002;
  localparam logic [11:0] OFF_RES = 12'h003;

  typedef enum logic [7:0] {
    MMULT1    = 8'h00,
    MMULT2    = 8'h01,
    MADD      = 8'h02,
    MSUB      = 8'h03,
    MTRANS    = 8'h04,
    MINV      = 8'h05,
    MSCALE    = 8'h06,
    MSCALEIMM = 8'h07,
    INTADD    = 8'h10,
    INTSUB    = 8'h11,
    INTMUL    = 8'h12,
    INTDIV    = 8'h13,
    STOP      = 8'hFF
  } opcode_e;

  typedef enum logic [3:0] {
    FETCH_RQ, FETCH_WT, DECODE,
    OPA_RQ, OPA_WT, WR_A,
    OPB_RQ, OPB_WT, WR_B,
    WR_OP, EXEC_WT, RES_RQ, RES_WT, WB, HALT
  } state_e;

  typedef struct packed {
    logic [7:0] opcode;
    logic [7:0] dest;
    logic [7:0] src1;
    logic [7:0] src2;
  } instr_t;

  function automatic logic is_mem_code(input logic [7:0] code);
    return code < 8'h10;
  endfunction

endpackage

// File: rtl/bus_master_port.sv
// Bus master port: owns the strobes, the tri-state driver and read timing.
// done is high in the last cycle of a transfer; rd_data is valid then.
module bus_master_port
  import seq_pkg::*;
(
  input  logic         clk,
  input  logic         nReset,
  input  logic         rd_req,
  input  logic         wr_req,
  input  logic [15:0]  req_addr,
  input  logic [255:0] wr_data,
  output logic         done,
  output logic [255:0] rd_data,
  inout  wire  [255:0] bus,
  output logic [15:0]  addr,
  output logic         nRead,
  output logic         nWrite
);

  typedef enum logic [1:0] {PH_IDLE, PH_RD1, PH_RD2, PH_WR} phase_e;

  phase_e       phase_reg;
  logic [15:0]  addr_reg;
  logic         nread_reg;
  logic         nwrite_reg;
  logic         drive_reg;
  logic [255:0] wdata_reg;

  // Requests are only accepted while idle, so a read and a write never overlap.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      phase_reg  <= PH_IDLE;
      addr_reg   <= '0;
      nread_reg  <= 1'b1;
      nwrite_reg <= 1'b1;
      drive_reg  <= 1'b0;
      wdata_reg  <= '0;
    end else begin
      case (phase_reg)
        PH_IDLE: begin
          if (rd_req) begin
            addr_reg  <= req_addr;
            nread_reg <= 1'b0;
            phase_reg <= PH_RD1;
          end else if (wr_req) begin
            addr_reg   <= req_addr;
            nwrite_reg <= 1'b0;
            drive_reg  <= 1'b1;
            wdata_reg  <= wr_data;
            phase_reg  <= PH_WR;
          end
        end
        PH_RD1: phase_reg <= PH_RD2;
        PH_RD2: begin
          nread_reg <= 1'b1;
          phase_reg <= PH_IDLE;
        end
        PH_WR: begin
          nwrite_reg <= 1'b1;
          drive_reg  <= 1'b0;
          phase_reg  <= PH_IDLE;
        end
        default: phase_reg <= PH_IDLE;
      endcase
    end
  end

  assign done    = (phase_reg == PH_RD2) || (phase_reg == PH_WR);
  assign rd_data = bus;
  assign bus     = drive_reg ? wdata_reg : 'z;
  assign addr    = addr_reg;
  assign nRead   = nread_reg;
  assign nWrite  = nwrite_reg;

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches, decodes and dispatches instructions to the
// matrix/integer ALUs over the shared bus, then writes results back.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int PC_W           = 12,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int NUM_REGS       = 4
) (
  input  logic            clk,
  input  logic            nReset,
  inout  wire  [255:0]    bus,
  output logic [15:0]     addr,
  output logic            nRead,
  output logic            nWrite,
  input  logic            exec_done,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic            error
);

  localparam int         TMO_W   = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int         REG_AW  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [7:0] REG_END = 8'(16 + NUM_REGS);

  state_e          state_reg, state_next;
  logic [PC_W-1:0] pc_reg, pc_next;
  instr_t          instr_reg, instr_next;
  logic [3:0]      unit_reg, unit_next;
  logic [255:0]    opa_reg, opa_next;
  logic [255:0]    opb_reg, opb_next;
  logic [255:0]    res_reg, res_next;
  logic [TMO_W-1:0] tmo_reg, tmo_next;
  logic            error_reg, error_next;
  logic [255:0]    regs [NUM_REGS];
  logic [NUM_REGS-1:0] reg_we;

  logic         rd_req, wr_req, port_done;
  logic [15:0]  req_addr;
  logic [255:0] wr_data, rd_data;

  function automatic logic is_reg_code(input logic [7:0] code);
    return (code >= 8'h10) && (code < REG_END);
  endfunction

  logic is_mat_op, is_int_op, is_imm_op, operands_ok;
  assign is_mat_op   = instr_reg.opcode <= MSCALEIMM;
  assign is_int_op   = (instr_reg.opcode >= INTADD) && (instr_reg.opcode <= INTDIV);
  assign is_imm_op   = instr_reg.opcode == MSCALEIMM;
  assign operands_ok = (is_mem_code(instr_reg.dest) || is_reg_code(instr_reg.dest)) &&
                       (is_mem_code(instr_reg.src1) || is_reg_code(instr_reg.src1)) &&
                       (is_imm_op || is_mem_code(instr_reg.src2) || is_reg_code(instr_reg.src2));

  bus_master_port u_port (
    .clk      (clk),
    .nReset   (nReset),
    .rd_req   (rd_req),
    .wr_req   (wr_req),
    .req_addr (req_addr),
    .wr_data  (wr_data),
    .done     (port_done),
    .rd_data  (rd_data),
    .bus      (bus),
    .addr     (addr),
    .nRead    (nRead),
    .nWrite   (nWrite)
  );

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_reg <= FETCH_RQ;
      pc_reg    <= '0;
      instr_reg <= '0;
      unit_reg  <= '0;
      opa_reg   <= '0;
      opb_reg   <= '0;
      res_reg   <= '0;
      tmo_reg   <= '0;
      error_reg <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      instr_reg <= instr_next;
      unit_reg  <= unit_next;
      opa_reg   <= opa_next;
      opb_reg   <= opb_next;
      res_reg   <= res_next;
      tmo_reg   <= tmo_next;
      error_reg <= error_next;
      for (int i = 0; i < NUM_REGS; i++)
        if (reg_we[i]) regs[i] <= res_reg;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    instr_next = instr_reg;
    unit_next  = unit_reg;
    opa_next   = opa_reg;
    opb_next   = opb_reg;
    res_next   = res_reg;
    tmo_next   = tmo_reg;
    error_next = error_reg;
    rd_req     = 1'b0;
    wr_req     = 1'b0;
    req_addr   = '0;
    wr_data    = '0;
    reg_we     = '0;
    case (state_reg)
      FETCH_RQ: begin
        rd_req     = 1'b1;
        req_addr   = {ROM_ID, 12'(pc_reg)};
        state_next = FETCH_WT;
      end
      FETCH_WT: if (port_done) begin
        instr_next = rd_data[31:0];
        state_next = DECODE;
      end
      DECODE: begin
        if (instr_reg.opcode == STOP) begin
          state_next = HALT;
        end else if (!(is_mat_op || is_int_op) || !operands_ok) begin
          error_next = 1'b1;
          state_next = HALT;
        end else begin
          unit_next  = is_int_op ? INT_ID : MATRIX_ID;
          state_next = OPA_RQ;
        end
      end
      OPA_RQ: begin
        if (is_reg_code(instr_reg.src1)) begin
          opa_next   = regs[instr_reg.src1[REG_AW-1:0]];
          state_next = WR_A;
        end else begin
          rd_req     = 1'b1;
          req_addr   = {MEM_ID, 4'h0, instr_reg.src1};
          state_next = OPA_WT;
        end
      end
      OPA_WT: if (port_done) begin
        opa_next   = rd_data;
        state_next = WR_A;
      end
      WR_A: begin
        wr_req   = 1'b1;
        req_addr = {unit_reg, OFF_A};
        wr_data  = opa_reg;
        if (port_done) state_next = OPB_RQ;
      end
      // MScaleImm carries an immediate scale factor in src2.
      OPB_RQ: begin
        if (is_imm_op) begin
          opb_next   = 256'(instr_reg.src2);
          state_next = WR_B;
        end else if (is_reg_code(instr_reg.src2)) begin
          opb_next   = regs[instr_reg.src2[REG_AW-1:0]];
          state_next = WR_B;
        end else begin
          rd_req     = 1'b1;
          req_addr   = {MEM_ID, 4'h0, instr_reg.src2};
          state_next = OPB_WT;
        end
      end
      OPB_WT: if (port_done) begin
        opb_next   = rd_data;
        state_next = WR_B;
      end
      WR_B: begin
        wr_req   = 1'b1;
        req_addr = {unit_reg, OFF_B};
        wr_data  = opb_reg;
        if (port_done) state_next = WR_OP;
      end
      WR_OP: begin
        wr_req   = 1'b1;
        req_addr = {unit_reg, OFF_OP};
        wr_data  = 256'(instr_reg.opcode);
        if (port_done) begin
          tmo_next   = '0;
          state_next = EXEC_WT;
        end
      end
      // A done pulse on the final counted cycle still wins over the timeout.
      EXEC_WT: begin
        if (exec_done) begin
          state_next = RES_RQ;
        end else if (tmo_reg == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          error_next = 1'b1;
          state_next = HALT;
        end else begin
          tmo_next = tmo_reg + TMO_W'(1);
        end
      end
      RES_RQ: begin
        rd_req     = 1'b1;
        req_addr   = {unit_reg, OFF_RES};
        state_next = RES_WT;
      end
      RES_WT: if (port_done) begin
        res_next   = rd_data;
        state_next = WB;
      end
      WB: begin
        if (is_reg_code(instr_reg.dest)) begin
          reg_we[instr_reg.dest[REG_AW-1:0]] = 1'b1;
          pc_next    = pc_reg + PC_W'(1);
          state_next = FETCH_RQ;
        end else begin
          wr_req   = 1'b1;
          req_addr = {MEM_ID, 4'h0, instr_reg.dest};
          wr_data  = res_reg;
          if (port_done) begin
            pc_next    = pc_reg + PC_W'(1);
            state_next = FETCH_RQ;
          end
        end
      end
      HALT: state_next = HALT;
      default: state_next = HALT;
    endcase
  end

  assign pc     = pc_reg;
  assign halted = state_reg == HALT;
  assign error  = error_reg;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: stimulus queues the expected bus
// transactions, a negedge monitor models the peripherals and checks them.
module tb_instr_sequencer;

  localparam int TIMEOUT = 1024;

  logic         clk = 1'b0;
  logic         nReset = 1'b0;
  wire  [255:0] bus;
  logic [15:0]  addr;
  logic         nRead, nWrite;
  logic         exec_done = 1'b0;
  logic [11:0]  pc;
  logic         halted, error;

  logic         tb_drive = 1'b0;
  logic [255:0] tb_data = '0;
  assign bus = tb_drive ? tb_data : 'z;

  always #5 clk = ~clk;

  instr_sequencer #(.PC_W(12), .TIMEOUT_CYCLES(TIMEOUT), .NUM_REGS(4)) dut (
    .clk       (clk),
    .nReset    (nReset),
    .bus       (bus),
    .addr      (addr),
    .nRead     (nRead),
    .nWrite    (nWrite),
    .exec_done (exec_done),
    .pc        (pc),
    .halted    (halted),
    .error     (error)
  );

  typedef struct {
    bit           wr;
    logic [15:0]  a;
    logic [255:0] d;
  } txn_t;

  txn_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   wr4002_cyc = -1;
  int   wr4002_cnt = 0;
  int   stray_cyc = -1;
  int   done_cnt = 0;
  bit   hang_int = 0;
  bit   prev_nread = 1;

  logic [31:0]  rom [16];
  logic [255:0] mem [16];
  logic [255:0] alu_a = '0, alu_b = '0, alu_res = '0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic push(input bit wr, input logic [15:0] a, input logic [255:0] d);
    txn_t t;
    t.wr = wr; t.a = a; t.d = d;
    exp_q.push_back(t);
  endtask

  function automatic logic [255:0] periph_read(input logic [15:0] a);
    logic [255:0] v;
    v = '0;
    case (a[15:12])
      4'd1: v = mem[a[3:0]];
      4'd2: v = {224'b0, rom[a[3:0]]};
      4'd3, 4'd4: if (a[11:0] == 12'h003) v = alu_res;
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic score(input bit wr, input logic [15:0] a, input logic [255:0] d);
    txn_t e;
    $display("txn %s addr=%h data=%h", wr ? "WR" : "RD", a, d);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_txn: got %s %h want none", wr ? "WR" : "RD", a);
    end else begin
      e = exp_q.pop_front();
      check("txn_kind", 256'(wr), 256'(e.wr));
      check("txn_addr", 256'(a), 256'(e.a));
      if (wr) check("txn_data", d, e.d);
    end
  endtask

  // Peripheral models and bus monitor; peripherals drive from the negedge.
  always @(negedge clk) begin
    if (!nReset) begin
      tb_drive   = 1'b0;
      done_cnt   = 0;
      exec_done  = 1'b0;
      prev_nread = 1'b1;
    end else begin
      exec_done = (cyc == stray_cyc);
      if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) exec_done = 1'b1;
      end
      if (!nRead && !nWrite) check("strobe_overlap", 256'({nRead, nWrite}), 256'(1));
      if (!nWrite) begin
        score(1'b1, addr, bus);
        if (addr[15:12] == 4'd3 || addr[15:12] == 4'd4) begin
          case (addr[11:0])
            12'h000: alu_a = bus;
            12'h001: alu_b = bus;
            12'h002: begin
              alu_res = alu_a + alu_b + {248'b0, bus[7:0]};
              if (!(addr[15:12] == 4'd4 && hang_int)) done_cnt = 5;
              if (addr == 16'h4002) begin
                wr4002_cyc = cyc;
                wr4002_cnt++;
              end
            end
            default: ;
          endcase
        end
      end
      if (!nRead && prev_nread) score(1'b0, addr, '0);
      tb_drive = !nRead;
      if (!nRead) tb_data = periph_read(addr);
      prev_nread = nRead;
    end
  end

  task automatic begin_test();
    nReset = 1'b0;
    hang_int = 0;
    stray_cyc = -1;
    repeat (2) @(negedge clk);
    exp_q.delete();
    for (int i = 0; i < 16; i++) rom[i] = 32'hFF000000;
  endtask

  task automatic release_reset();
    @(negedge clk);
    nReset = 1'b1;
  endtask

  task automatic wait_halt(input int budget, output int at_cyc);
    at_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (halted) begin
        at_cyc = cyc;
        break;
      end
    end
    if (at_cyc < 0) begin
      total++;
      bad++;
      $display("FAIL halt_wait: got no halt within %0d cycles want halted=1", budget);
    end
  endtask

  task automatic end_test(input string name, input logic [11:0] exp_pc, input logic exp_err);
    repeat (4) @(negedge clk);
    check({name, "_halted"}, 256'(halted), 256'(1));
    check({name, "_error"}, 256'(error), 256'(exp_err));
    check({name, "_pc"}, 256'(pc), 256'(exp_pc));
    check({name, "_strobes"}, 256'({nRead, nWrite}), 256'(3));
    check({name, "_drained"}, 256'(exp_q.size()), 256'(0));
  endtask

  localparam logic [255:0] VA  = {64'h1111, 192'h11};
  localparam logic [255:0] VB  = {64'h2222, 192'h22};
  localparam logic [255:0] VR  = {64'h3333, 192'h36};
  localparam logic [255:0] M3  = {64'h5, 192'h40};
  localparam logic [255:0] M5  = {64'h10, 192'h1};
  localparam logic [255:0] R1  = {64'h5, 192'h4F};
  localparam logic [255:0] R2  = {64'h15, 192'h50};
  localparam logic [255:0] M0  = {64'h77, 192'h9};

  initial begin
    int hc;
    int cnt0;
    for (int i = 0; i < 16; i++) mem[i] = '0;

    // Reset values and STOP at address 0
    begin_test();
    check("rst_addr", 256'(addr), 256'(0));
    check("rst_nread", 256'(nRead), 256'(1));
    check("rst_nwrite", 256'(nWrite), 256'(1));
    check("rst_pc", 256'(pc), 256'(0));
    check("rst_halted", 256'(halted), 256'(0));
    check("rst_error", 256'(error), 256'(0));
    push(0, 16'h2000, '0);
    release_reset();
    wait_halt(200, hc);
    end_test("stop", 12'd0, 1'b0);

    // Memory-to-memory matrix op with a stray exec_done during fetch
    begin_test();
    rom[0] = 32'h03020001;
    mem[0] = VA;
    mem[1] = VB;
    push(0, 16'h2000, '0);
    push(0, 16'h1000, '0);
    push(1, 16'h3000, VA);
    push(0, 16'h1001, '0);
    push(1, 16'h3001, VB);
    push(1, 16'h3002, 256'h3);
    push(0, 16'h3003, '0);
    push(1, 16'h1002, VR);
    push(0, 16'h2001, '0);
    release_reset();
    stray_cyc = cyc + 4;
    wait_halt(500, hc);
    end_test("madd", 12'd1, 1'b0);

    // Immediate operand, register destination, then register source
    begin_test();
    rom[0] = 32'h07110308;
    rom[1] = 32'h00061105;
    mem[3] = M3;
    mem[5] = M5;
    push(0, 16'h2000, '0);
    push(0, 16'h1003, '0);
    push(1, 16'h3000, M3);
    push(1, 16'h3001, 256'h08);
    push(1, 16'h3002, 256'h07);
    push(0, 16'h3003, '0);
    push(0, 16'h2001, '0);
    push(1, 16'h3000, R1);
    push(0, 16'h1005, '0);
    push(1, 16'h3001, M5);
    push(1, 16'h3002, 256'h00);
    push(0, 16'h3003, '0);
    push(1, 16'h1006, R2);
    push(0, 16'h2002, '0);
    release_reset();
    wait_halt(800, hc);
    end_test("regs", 12'd2, 1'b0);

    // Execution timeout on the integer unit
    begin_test();
    rom[0] = 32'h13000000;
    mem[0] = M0;
    hang_int = 1;
    push(0, 16'h2000, '0);
    push(0, 16'h1000, '0);
    push(1, 16'h4000, M0);
    push(0, 16'h1000, '0);
    push(1, 16'h4001, M0);
    push(1, 16'h4002, 256'h13);
    release_reset();
    wait_halt(TIMEOUT + 300, hc);
    // The unit samples the opcode write at the edge after the write cycle;
    // halted must rise exactly TIMEOUT cycles after that edge.
    check("timeout_latency", 256'(hc - wr4002_cyc), 256'(TIMEOUT + 1));
    end_test("timeout", 12'd0, 1'b1);

    // Illegal opcode
    begin_test();
    rom[0] = 32'h20000000;
    push(0, 16'h2000, '0);
    release_reset();
    wait_halt(200, hc);
    end_test("badop", 12'd0, 1'b1);

    // Illegal operand code
    begin_test();
    rom[0] = 32'h03003001;
    push(0, 16'h2000, '0);
    release_reset();
    wait_halt(200, hc);
    end_test("badsrc", 12'd0, 1'b1);

    // Asynchronous reset while waiting for the integer unit
    begin_test();
    rom[0] = 32'h07110308;
    rom[1] = 32'h13000000;
    mem[0] = M0;
    mem[3] = M3;
    hang_int = 1;
    push(0, 16'h2000, '0);
    push(0, 16'h1003, '0);
    push(1, 16'h3000, M3);
    push(1, 16'h3001, 256'h08);
    push(1, 16'h3002, 256'h07);
    push(0, 16'h3003, '0);
    push(0, 16'h2001, '0);
    push(0, 16'h1000, '0);
    push(1, 16'h4000, M0);
    push(0, 16'h1000, '0);
    push(1, 16'h4001, M0);
    push(1, 16'h4002, 256'h13);
    cnt0 = wr4002_cnt;
    release_reset();
    for (int i = 0; i < 600 && wr4002_cnt == cnt0; i++) @(negedge clk);
    check("midrst_reached_exec", 256'(wr4002_cnt - cnt0), 256'(1));
    repeat (10) @(negedge clk);
    check("midrst_pc_before", 256'(pc), 256'(1));
    check("midrst_drained", 256'(exp_q.size()), 256'(0));
    #2 nReset = 1'b0;
    #1;
    check("midrst_addr", 256'(addr), 256'(0));
    check("midrst_strobes", 256'({nRead, nWrite}), 256'(3));
    check("midrst_pc", 256'(pc), 256'(0));
    check("midrst_halted", 256'(halted), 256'(0));
    check("midrst_error", 256'(error), 256'(0));
    @(negedge clk);
    hang_int = 0;
    rom[0] = 32'hFF000000;
    push(0, 16'h2000, '0);
    release_reset();
    wait_halt(200, hc);
    end_test("resume", 12'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Bus-master control unit that sequences the shared 256-bit system bus for the processor.
- Fetches 32-bit instructions from the instruction ROM (peripheral 2) using a program counter.
- Decodes each instruction, gathers operands from main memory or its internal matrix registers, and dispatches them to the matrix ALU or integer ALU peripheral.
- Waits for completion, writes the result back, and halts on STOP (FFh), an illegal opcode, or an execution timeout.

Parameters:
- PC_W, 12, program counter width; equals the ROM word-select field addr[11:0].
- TIMEOUT_CYCLES, 1024, maximum cycles allowed between the opcode write and exec_done before an error halt.
- NUM_REGS, 4, number of internal 256-bit registers, selected by operand codes 10h-13h.

Ports:
- clk, in, 1, clock; all sequencer state changes on the posedge.
- nReset, in, 1, reset; asynchronous, active-low.
- bus, inout, 256, shared system bus; driven only during write cycles, 'z otherwise.
- addr, out, 16, [15:12] peripheral id, [11:0] word select.
- nRead, out, 1, active-low read strobe.
- nWrite, out, 1, active-low write strobe.
- exec_done, in, 1, one-cycle pulse from the active ALU when its result is ready.
- pc, out, PC_W, address of the current instruction.
- halted, out, 1, high in HALT.
- error, out, 1, high when the halt was caused by an illegal opcode or a timeout.

Behaviour:
- Reset values: addr=0, nRead=1, nWrite=1, bus released, pc=0, halted=0, error=0, registers cleared, state=FETCH_RQ. Reset mid-operation aborts any transfer and releases the bus immediately.
- Peripheral ids (package constants): MEM_ID=1, ROM_ID=2, MATRIX_ID=3, INT_ID=4.
- Instruction fields: opcode[31:24], dest[23:16], src1[15:8], src2[7:0].
- Operand codes:
  - 00h-0Fh: main-memory word at that address.
  - 10h-13h: internal register [code[1:0]].
  - Any other code: illegal; error halt.
- Read cycle:
  - Posedge N: drive addr and nRead=0.
  - Posedge N+1: hold.
  - Posedge N+2: capture bus and set nRead=1.
  - Read latency is 2 cycles; the peripheral drives the bus from the negedge after it decodes.
- Write cycle: drive addr, nWrite=0 and bus=data for exactly one cycle; on the next posedge release the bus and set nWrite=1.
- FSM:
  - FETCH_RQ/FETCH_WT: read {ROM_ID, pc}; instruction = bus[31:0].
  - DECODE:
    - FFh -> HALT.
    - 00h-07h -> unit MATRIX_ID; 10h-13h -> unit INT_ID.
    - Any other opcode -> HALT with error=1.
  - OPA_RQ/OPA_WT: read src1 from memory; register operands skip the bus read (0 cycles).
  - WR_A: write operand A to {unit, 000h}.
  - OPB_RQ/OPB_WT: as for A. For opcode 07h (MScaleImm), src2 is an immediate, zero-extended to 256 bits, with no read.
  - WR_B: write to {unit, 001h}.
  - WR_OP: write the zero-extended opcode to {unit, 002h}; this write starts the unit. The timeout counter is cleared.
  - EXEC_WT:
    - Wait for exec_done.
    - Counter reaches TIMEOUT_CYCLES -> HALT with error=1.
    - exec_done in the same cycle as the limit: done wins.
  - RES_RQ/RES_WT: read {unit, 003h}.
  - WB: memory dest -> write {MEM_ID, dest}; register dest -> load internal register, no bus cycle.
  - Then pc <= pc+1 and return to FETCH_RQ.
  - HALT: terminal until reset; strobes high, bus released.
- pc wraps from 2^PC_W-1 to 0 with no flag.
- The sequencer never drives the bus while nRead is low, and never asserts nRead and nWrite together.
- exec_done outside EXEC_WT is ignored.

Decomposition:
- Package seq_pkg contains:
  - Peripheral id constants.
  - Opcode enum (MMULT1..MSCALEIMM, INTADD..INTDIV, STOP).
  - Unit-offset constants 0-3.
  - The state enum.
  - An instr_t packed struct {opcode, dest, src1, src2}.
- One natural sub-module: bus_master_port. It owns the tri-state driver, the strobe timing and the 2-cycle read capture, and gives a req/done handshake to the FSM.

Test Plan:
- Reset, then ROM[0]=FF000000 -> one fetch of addr 2000h; halted=1 after DECODE, error=0, pc=0, no writes issued.
- ROM[0]=03020001, mem[0]=A, mem[1]=B, matrix model returns R, exec_done 5 cycles after the opcode write:
  - Writes must occur in order: 3000h=A, 3001h=B, 3002h=3.
  - Then read 3003h and write 1002h=R.
  - Then fetch 2001h.
- ROM[0]=07110308 -> no bus read for src2; write 3001h = 256'h08. Result loads reg[1] with no MEM write. A following 00061105 reads reg[1] as operand A with no bus read.
- ROM[0]=13000000 (IntDiv), exec_done never arrives -> halted=1 and error=1 exactly TIMEOUT_CYCLES after the 4002h write.
- Illegal opcode 20h, or operand code 30h -> error halt, bus released, nWrite stays 1.
- nReset asserted mid-EXEC_WT -> outputs return to reset values asynchronously. After release, a fetch from 2000h resumes.
